// File: rtl/iir_sos_sched.sv
// Time-multiplexed cascade of NS transposed-direct-form-II biquads sharing one signed multiplier.
// Latency: accept edge T -> out_valid in cycle T+5*NS+1; one sample per 5*NS+2 cycles.
// Backpressure: in_ready low from accept until the return to IDLE; in_valid is ignored meanwhile.
module iir_sos_sched #(
    parameter int W   = 32,
    parameter int FSW = 16,
    parameter int NS  = 4,
    localparam int AW = $clog2(5*NS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in,
    output logic                out_valid,
    output logic signed [W-1:0] out,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic signed [W-1:0] cfg_data,
    output logic                cfg_err,
    input  logic                clr_state
);

    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [2:0] {IDLE, B0, B1, A1, B2, A2, DONE} state_t;

    state_t              state;
    logic [SW-1:0]       s;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] acc;

    // Coefficient bank, index = section*5 + k (b0, b1, b2, a1, a2)
    logic signed [W-1:0] coef [5*NS];
    // Per-section delay states
    logic signed [W-1:0] d0 [NS];
    logic signed [W-1:0] d1 [NS];

    logic [AW-1:0]         cbase;
    logic signed [W-1:0]   mul_c;
    logic signed [W-1:0]   mul_v;
    logic signed [2*W-1:0] full;
    logic signed [W-1:0]   prod;
    logic                  addr_ok;

    assign cbase   = AW'(s) * AW'(5);
    assign addr_ok = (cfg_addr < AW'(5*NS));

    // Shared multiplier operand select: coefficient and operand depend on the step
    always_comb begin
        mul_c = '0;
        mul_v = '0;
        case (state)
            B0: begin mul_c = coef[cbase];          mul_v = x; end
            B1: begin mul_c = coef[cbase + AW'(1)]; mul_v = x; end
            A1: begin mul_c = coef[cbase + AW'(3)]; mul_v = y; end
            B2: begin mul_c = coef[cbase + AW'(2)]; mul_v = x; end
            A2: begin mul_c = coef[cbase + AW'(4)]; mul_v = y; end
            default: ;
        endcase
    end

    // Full-width product, floor-shifted back to Q format and wrapped to W bits
    assign full = (2*W)'(mul_c) * (2*W)'(mul_v);
    assign prod = W'(full >>> FSW);

    // Sequencer: walks the five multiply steps per section and owns the output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            x         <= '0;
            y         <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            cfg_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            cfg_err   <= cfg_we && ((state != IDLE) || !addr_ok);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= in;
                        s        <= '0;
                        in_ready <= 1'b0;
                        state    <= B0;
                    end
                end
                B0: begin
                    y     <= prod + d0[s];
                    state <= B1;
                end
                B1: begin
                    acc   <= prod;
                    state <= A1;
                end
                A1: begin
                    state <= B2;
                end
                B2: begin
                    acc   <= prod;
                    state <= A2;
                end
                A2: begin
                    if (s != SW'(NS-1)) begin
                        x     <= y;
                        s     <= s + SW'(1);
                        state <= B0;
                    end else begin
                        out       <= y;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Coefficient writes are only honoured while idle and in range
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5*NS; i++) coef[i] <= '0;
        end else if (state == IDLE && cfg_we && addr_ok) begin
            coef[cfg_addr] <= cfg_data;
        end
    end

    // Delay-state updates; an idle clear lands before any sample accepted at the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                d0[i] <= '0;
                d1[i] <= '0;
            end
        end else begin
            if (state == IDLE && clr_state) begin
                for (int i = 0; i < NS; i++) begin
                    d0[i] <= '0;
                    d1[i] <= '0;
                end
            end
            if (state == A1) d0[s] <= acc - prod + d1[s];
            if (state == A2) d1[s] <= acc - prod;
        end
    end

endmodule

// File: tb/tb_iir_sos_sched.sv
// Self-checking bench for iir_sos_sched: directed steps plus randomized samples against a
// plain-arithmetic cascade model kept here.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_iir_sos_sched;
    localparam int W   = 32;
    localparam int FSW = 16;
    localparam int NS  = 4;
    localparam int AW  = $clog2(5*NS);

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in;
    logic                out_valid;
    logic signed [W-1:0] out;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic signed [W-1:0] cfg_data;
    logic                cfg_err;
    logic                clr_state;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;

    int mcoef [5*NS];
    int md0 [NS];
    int md1 [NS];

    always #5 clk = ~clk;

    iir_sos_sched #(.W(W), .FSW(FSW), .NS(NS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out(out),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .clr_state(clr_state)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: Q-format product with floor, wrap to 32 bits
    function automatic int pm(input int c, input int v);
        longint pr;
        pr = longint'(c) * longint'(v);
        pr = pr >>> FSW;
        return int'(pr);
    endfunction

    // Reference cascade: y = b0 x + d0; d0' = b1 x - a1 y + d1; d1' = b2 x - a2 y
    function automatic int model_step(input int xin);
        int xv, yv, n0, n1;
        xv = xin;
        yv = 0;
        for (int k = 0; k < NS; k++) begin
            yv = pm(mcoef[5*k], xv) + md0[k];
            n0 = pm(mcoef[5*k+1], xv) - pm(mcoef[5*k+3], yv) + md1[k];
            n1 = pm(mcoef[5*k+2], xv) - pm(mcoef[5*k+4], yv);
            md0[k] = n0;
            md1[k] = n1;
            xv = yv;
        end
        return yv;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 5*NS; k++) mcoef[k] = 0;
        for (int k = 0; k < NS; k++) begin md0[k] = 0; md1[k] = 0; end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && in_ready !== 1'b1; i++) tick();
        if (in_ready !== 1'b1) check("idle_timeout", in_ready, 1);
    endtask

    task automatic wcoef(input int addr, input int data);
        wait_idle();
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_data = data;
        tick();
        cfg_we = 1'b0;
        if (addr < 5*NS) mcoef[addr] = data;
    endtask

    task automatic clr();
        wait_idle();
        clr_state = 1'b1;
        tick();
        clr_state = 1'b0;
        for (int k = 0; k < NS; k++) begin md0[k] = 0; md1[k] = 0; end
    endtask

    task automatic start(input int xin);
        wait_idle();
        in = xin; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; lat = edges from accept to the strobe cycle
    task automatic wait_out(input int pre, output int yv, output int lat, output int busy_bad);
        lat = -1;
        busy_bad = (in_ready !== 1'b0) ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (out_valid === 1'b1) begin lat = i + pre; break; end
            if (in_ready !== 1'b0) busy_bad = 1;
        end
        yv = out;
    endtask

    task automatic run_chk(input int xin, input int exp_y, input string tag);
        int yv, lat, bad;
        start(xin);
        wait_out(0, yv, lat, bad);
        check({tag, "_lat"}, lat, 5*NS);
        check({tag, "_busy"}, bad, 0);
        check(tag, yv, exp_y);
    endtask

    initial begin
        int yv, lat, bad, m, xr, newc, cur, last_acc, rdy, seen;
        int expq[$];

        model_reset();
        rst = 1'b1; in_valid = 1'b1; in = 5; cfg_we = 1'b0; cfg_addr = '0;
        cfg_data = '0; clr_state = 1'b0;

        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out_valid", out_valid, 0);
            check("rst_out", out, 0);
            check("rst_cfg_err", cfg_err, 0);
        end
        rst = 1'b0; in_valid = 1'b0;
        check("rst_in_ready", in_ready, 1);
        tick();
        check("post_rst_out_valid", out_valid, 0);

        // Passthrough, unity b0
        for (int k = 0; k < NS; k++) wcoef(5*k, 65536);
        m = model_step(1234);
        run_chk(1234, 1234, "pass");
        tick();
        check("strobe_once", out_valid, 0);
        check("out_hold", out, 1234);

        // Half gain per section: floor keeps -1 at -1
        for (int k = 0; k < NS; k++) wcoef(5*k, 32768);
        m = model_step(-1);
        run_chk(-1, -1, "floor");

        // Single pole in section 0
        clr();
        wcoef(0, 65536);
        wcoef(3, -32768);
        for (int k = 1; k < NS; k++) wcoef(5*k, 65536);
        m = model_step(1000); run_chk(1000, 1000, "pole0");
        m = model_step(0);    run_chk(0, 500, "pole1");
        m = model_step(0);    run_chk(0, 250, "pole2");
        m = model_step(0);    run_chk(0, 125, "pole3");
        clr();
        m = model_step(0);    run_chk(0, 0, "pole_clr");

        // Random coefficients and samples against the model
        for (int k = 0; k < 5*NS; k++) wcoef(k, int'($urandom_range(0, 262143)) - 131072);
        clr();
        for (int i = 0; i < 8; i++) begin
            xr = int'($urandom);
            m = model_step(xr);
            run_chk(xr, m, "rand");
        end

        // Coefficient write and state clear in the same cycle as the accept
        wait_idle();
        newc = int'($urandom_range(0, 131071)) - 65536;
        xr = int'($urandom_range(0, 200000)) - 100000;
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = newc; clr_state = 1'b1;
        in = xr; in_valid = 1'b1;
        tick();
        cfg_we = 1'b0; clr_state = 1'b0; in_valid = 1'b0;
        check("same_cycle_cfg_err", cfg_err, 0);
        mcoef[0] = newc;
        for (int k = 0; k < NS; k++) begin md0[k] = 0; md1[k] = 0; end
        m = model_step(xr);
        wait_out(0, yv, lat, bad);
        check("same_cycle_lat", lat, 5*NS);
        check("same_cycle", yv, m);

        // Backpressure: in_valid held high, data advances per accept
        clr();
        cur = 100; in = cur; in_valid = 1'b1; last_acc = -1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            rdy = (in_ready === 1'b1) ? 1 : 0;
            tick();
            if (out_valid === 1'b1) begin
                if (expq.size() > 0) check("bp_out", out, expq.pop_front());
                else check("bp_extra_strobe", out_valid, 0);
            end
            if (rdy == 1) begin
                if (last_acc >= 0) check("bp_gap", cyc - last_acc, 5*NS+2);
                last_acc = cyc;
                expq.push_back(model_step(cur));
                cur++;
                in = cur;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40 && expq.size() > 0; i++) begin
            tick();
            if (out_valid === 1'b1) check("bp_drain_out", out, expq.pop_front());
        end
        check("bp_drained", expq.size(), 0);
        check("bp_accepts", cur - 100, 5);

        // Config guard: write during A1 is dropped and flagged
        clr();
        for (int k = 0; k < 5*NS; k++) wcoef(k, (k % 5 == 0) ? 65536 : 0);
        start(777);
        tick();
        tick();
        cfg_we = 1'b1; cfg_addr = '0; cfg_data = 0;
        tick();
        cfg_we = 1'b0;
        check("guard_err_pulse", cfg_err, 1);
        tick();
        check("guard_err_clear", cfg_err, 0);
        m = model_step(777);
        wait_out(4, yv, lat, bad);
        check("guard_lat", lat, 5*NS);
        check("guard_b0_kept", yv, 777);

        // Out-of-range address while idle
        wait_idle();
        cfg_we = 1'b1; cfg_addr = AW'(5*NS); cfg_data = 5;
        tick();
        cfg_we = 1'b0;
        check("addr_err_pulse", cfg_err, 1);
        tick();
        check("addr_err_clear", cfg_err, 0);
        m = model_step(-4321);
        run_chk(-4321, -4321, "addr_no_effect");

        // Reset seven edges after accept aborts the sample
        start(555);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out", out, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1;
        end
        check("midrst_no_strobe", seen, 0);
        model_reset();
        for (int k = 0; k < NS; k++) wcoef(5*k, 65536);
        m = model_step(1234);
        run_chk(1234, 1234, "after_midrst");

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/iir_sos_sched.md
Name: iir_sos_sched

Overview:
- Time-multiplexed scheduler for a cascade of NS second-order IIR sections, all in transposed direct form II.
- One shared signed multiplier and a per-section coefficient/state bank replace NS parallel biquads.
- Accepts one sample per handshake, sequences the 5 coefficient multiplies of each section in turn, and emits the cascade output with a one-cycle valid strobe.
- Sits between the sample source (ADC front end) and downstream decimation/logging logic.

Parameters:
- W, 32, sample/coefficient/state word width, two's complement.
- FSW, 16, fractional bits of coefficients (Q(W-FSW).FSW); 1.0 = 2**FSW.
- NS, 4, number of cascaded sections (1..16).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler can accept a sample.
- in  in  W  signed input sample.
- out_valid  out  1  one-cycle strobe, out holds new result.
- out  out  W  signed cascade output; held until next strobe.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  clog2(5*NS)  coefficient index = section*5 + k; k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- cfg_data  in  W  signed coefficient, Q format per FSW.
- cfg_err  out  1  one-cycle pulse: write rejected.
- clr_state  in  1  zero all section delay states.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset (sampled high at a clk edge):
  - FSM returns to IDLE; in_ready=1 from the first cycle after rst is low.
  - out_valid=0, out=0, cfg_err=0.
  - All coefficients and all d0/d1 states are set to 0.
  - Reset mid-computation aborts the sample; no out_valid is produced for it.
- Product rule: p(c,v) = (c*v) computed at 2W bits, arithmetic-shifted right by FSW (floor, so -0.5 LSB becomes -1), then truncated to W bits. Adds and subtracts wrap at W bits; no saturation.
- FSM states: IDLE, B0, B1, A1, B2, A2, DONE. Section index s runs 0..NS-1. x = section input, y = section output.
  - IDLE: in_ready=1. When in_valid is high, latch x=in, set s=0, go to B0.
  - B0: y = p(b0,x) + d0[s].
  - B1: acc = p(b1,x).
  - A1: d0[s] = acc - p(a1,y) + d1[s], using the old d1[s].
  - B2: acc = p(b2,x).
  - A2: d1[s] = acc - p(a2,y). If s<NS-1, set x=y, s=s+1, go to B0; otherwise go to DONE.
  - DONE: out=y, out_valid=1 for this cycle only, return to IDLE.
- Exactly one multiply per cycle in every state from B0 to A2.
- Timing:
  - Accept at edge T → out_valid high in cycle T+5*NS+1 (cycle 21 for NS=4).
  - in_ready is low from T+1 until the return to IDLE.
  - Throughput: one sample per 5*NS+2 cycles.
- Backpressure: in_valid asserted while in_ready=0 is ignored. The source must hold in until accepted.
- cfg_we:
  - In IDLE: the write takes effect at the edge. A coefficient written in the same cycle as a sample is accepted applies to that sample.
  - Outside IDLE: the write is dropped and cfg_err pulses next cycle.
  - cfg_addr >= 5*NS: the write is dropped and cfg_err pulses.
- clr_state:
  - Acts only in IDLE; zeroes all d0/d1 at the edge and does not touch coefficients.
  - If clr_state and an accepted in_valid occur together, the clear happens first and the sample sees zero state.
  - Outside IDLE, clr_state is ignored.
- Simultaneous rst with any other input: rst wins.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 → during and after reset out_valid=0, out=0, cfg_err=0; in_ready=1 on the first cycle after rst falls.
- Passthrough: all sections b0=65536, other coefficients 0; accept in=1234 at T → out_valid only in cycle T+21, out=1234. Repeat with every b0=32768 and in=-1 → out=-1 (floor rounding).
- Single pole: section 0 b0=65536, a1=-32768, other coefficients 0; sections 1-3 passthrough; feed 1000,0,0,0 → outputs 1000,500,250,125. Then pulse clr_state in IDLE and feed 0 → output 0.
- Backpressure: in_valid held high with incrementing data for 100 cycles → accepts exactly every 22 cycles; in_ready low between accepts; outputs match a golden model per accepted sample.
- Config guard: cfg_we in state A1 with addr 0 → cfg_err pulses next cycle and b0 is unchanged in the next result. cfg_addr=20 with NS=4 in IDLE → cfg_err pulses.
- Reset mid-sample: assert rst 7 cycles after accept → no out_valid for that sample; a following sample in=1234 (coefficients reloaded for passthrough) → out=1234 with zero state.
